// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register for the 32-bit MIPS core, feeding the ALU.
//
// The stage captures decoded operands and control bits from decode.
// It resolves RAW hazards by forwarding from the MEM and WB stages.
// It detects load-use hazards and inserts a bubble when one occurs.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   id_*                           decoded instruction from the ID stage
//   mem_regwrite/mem_rd/mem_result MEM-stage forwarding source
//   wb_regwrite/wb_rd/wb_result    WB-stage forwarding source
//   flush                          discard the instruction entering EX
//   hold                           downstream freeze; EX keeps its contents
//   RA, RB, alufunc, shamt         registered ALU inputs
//   ex_valid, ex_regwrite,
//   ex_memread, ex_memwrite,
//   ex_rd, ex_store_data           registered EX-stage state
//   stall                          combinational; freezes PC and IF/ID
module id_ex_stage #(
  parameter logic [5:0] BUBBLE_FUNC = 6'b100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic [5:0]  id_alufunc,
  input  logic [4:0]  id_shamt,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  input  logic        flush,
  input  logic        hold,
  output logic [31:0] RA,
  output logic [31:0] RB,
  output logic [5:0]  alufunc,
  output logic [4:0]  shamt,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        stall
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rd;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] store_data;
    logic [5:0]  alufunc;
    logic [4:0]  shamt;
  } ex_regs_t;

  ex_regs_t    ex_q;
  ex_regs_t    ex_d;
  ex_regs_t    bubble_c;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic        load_use;

  // Operand forwarding: the younger MEM result beats WB.
  // Register 0 is hard-wired to zero, so it is never forwarded.
  always_comb begin
    rs_fwd = id_rs_data;
    if (mem_regwrite && (mem_rd == id_rs) && (id_rs != 5'd0)) begin
      rs_fwd = mem_result;
    end else if (wb_regwrite && (wb_rd == id_rs) && (id_rs != 5'd0)) begin
      rs_fwd = wb_result;
    end

    rt_fwd = id_rt_data;
    if (mem_regwrite && (mem_rd == id_rt) && (id_rt != 5'd0)) begin
      rt_fwd = mem_result;
    end else if (wb_regwrite && (wb_rd == id_rt) && (id_rt != 5'd0)) begin
      rt_fwd = wb_result;
    end
  end

  // A load in EX cannot forward its data yet.
  // A dependent instruction in ID must therefore wait one cycle.
  // stall depends only on registered EX state and inputs, never on ex_d.
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
    stall    = load_use || hold;
  end

  // Next EX contents.
  // flush outranks hold, so a redirect can clear a frozen stage.
  // On a load-use hazard, a bubble is loaded while stall holds the
  // decode instruction in place upstream.
  always_comb begin
    bubble_c         = '0;
    bubble_c.alufunc = BUBBLE_FUNC;

    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble_c;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = bubble_c;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.regwrite   = id_regwrite && id_valid;
      ex_d.memread    = id_memread && id_valid;
      ex_d.memwrite   = id_memwrite && id_valid;
      ex_d.rd         = id_rd;
      ex_d.ra         = rs_fwd;
      ex_d.rb         = id_use_imm ? id_imm : rt_fwd;
      ex_d.store_data = rt_fwd;
      ex_d.alufunc    = id_alufunc;
      ex_d.shamt      = id_shamt;
    end
  end

  // EX register, with a synchronous reset to the bubble state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= bubble_c;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign RA            = ex_q.ra;
  assign RB            = ex_q.rb;
  assign alufunc       = ex_q.alufunc;
  assign shamt         = ex_q.shamt;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_rd         = ex_q.rd;
  assign ex_store_data = ex_q.store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage.
// A behavioural model of the EX register is kept alongside the DUT.
// Directed scenarios run first, followed by a randomized run.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [5:0]  id_alufunc;
  logic [4:0]  id_shamt;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        flush, hold;
  logic [31:0] RA, RB;
  logic [5:0]  alufunc;
  logic [4:0]  shamt;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        stall;

  int tests_run = 0;
  int failures  = 0;

  // Model of the EX register contents
  logic        m_valid, m_regwrite, m_memread, m_memwrite;
  logic [4:0]  m_rd, m_shamt;
  logic [31:0] m_ra, m_rb, m_store;
  logic [5:0]  m_func;

  id_ex_stage #(.BUBBLE_FUNC(6'b100000)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alufunc(id_alufunc), .id_shamt(id_shamt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .hold(hold),
    .RA(RA), .RB(RB), .alufunc(alufunc), .shamt(shamt),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forward a register value: the youngest matching writer supplies it.
  // Register 0 always reads its register-file value.
  function automatic logic [31:0] fwdValue(input logic [4:0] src, input logic [31:0] rf);
    if (src == 0) return rf;
    if (mem_regwrite && mem_rd == src) return mem_result;
    if (wb_regwrite && wb_rd == src) return wb_result;
    return rf;
  endfunction

  // A load-use hazard exists when a valid load in EX targets a register
  // that the valid ID instruction reads.
  function automatic logic modelLoadUse();
    return id_valid && m_valid && m_memread && m_rd != 0 &&
           (m_rd == id_rs || m_rd == id_rt);
  endfunction

  task automatic modelBubble();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0;
    m_rd = 0; m_ra = 0; m_rb = 0; m_store = 0; m_shamt = 0; m_func = 6'b100000;
  endtask

  task automatic modelEdge();
    logic lu;
    lu = modelLoadUse();
    if (rst || flush) modelBubble();
    else if (hold) begin end
    else if (lu) modelBubble();
    else begin
      m_valid    = id_valid;
      m_regwrite = id_valid && id_regwrite;
      m_memread  = id_valid && id_memread;
      m_memwrite = id_valid && id_memwrite;
      m_rd       = id_rd;
      m_ra       = fwdValue(id_rs, id_rs_data);
      m_store    = fwdValue(id_rt, id_rt_data);
      m_rb       = id_use_imm ? id_imm : m_store;
      m_func     = id_alufunc;
      m_shamt    = id_shamt;
    end
  endtask

  task automatic checkOutput();
    chk("RA", RA, m_ra);
    chk("RB", RB, m_rb);
    chk("alufunc", {26'd0, alufunc}, {26'd0, m_func});
    chk("shamt", {27'd0, shamt}, {27'd0, m_shamt});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m_regwrite});
    chk("ex_memread", {31'd0, ex_memread}, {31'd0, m_memread});
    chk("ex_memwrite", {31'd0, ex_memwrite}, {31'd0, m_memwrite});
    chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    chk("ex_store_data", ex_store_data, m_store);
  endtask

  // One cycle: check the combinational stall, clock the DUT and the
  // model together, and then compare the registered outputs.
  task automatic applyStimulus();
    #1;
    chk("stall", {31'd0, stall}, {31'd0, (hold || modelLoadUse())});
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic randomInputs(input int regMax);
    id_valid    = 1'($urandom);
    id_rs       = 5'($urandom_range(0, regMax));
    id_rt       = 5'($urandom_range(0, regMax));
    id_rd       = 5'($urandom_range(0, regMax));
    id_rs_data  = $urandom;
    id_rt_data  = $urandom;
    id_imm      = $urandom;
    id_use_imm  = 1'($urandom);
    id_alufunc  = 6'($urandom);
    id_shamt    = 5'($urandom);
    id_regwrite = 1'($urandom);
    id_memread  = 1'($urandom);
    id_memwrite = 1'($urandom);
    mem_regwrite = 1'($urandom);
    mem_rd      = 5'($urandom_range(0, regMax));
    mem_result  = $urandom;
    wb_regwrite = 1'($urandom);
    wb_rd       = 5'($urandom_range(0, regMax));
    wb_result   = $urandom;
  endtask

  task automatic quietInputs();
    randomInputs(3);
    id_valid = 1; id_memread = 0; id_memwrite = 0; id_use_imm = 0;
    mem_regwrite = 0; wb_regwrite = 0; flush = 0; hold = 0; rst = 0;
  endtask

  initial begin
    logic [31:0] savedRa;
    logic [5:0]  savedFunc;
    flush = 0; hold = 0; rst = 1;
    randomInputs(31);
    modelBubble();
    @(posedge clk); #1;

    // Reset for 2 cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      randomInputs(31);
      rst = 1; flush = 0; hold = 0;
      applyStimulus();
    end
    chk("reset_RA", RA, 32'd0);
    chk("reset_RB", RB, 32'd0);
    chk("reset_alufunc", {26'd0, alufunc}, 32'h20);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // MEM beats WB on the same register, then WB alone
    quietInputs();
    id_rs = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
    mem_result = 32'hAAAA0000; wb_result = 32'h5555;
    applyStimulus();
    chk("fwd_mem_prio", RA, 32'hAAAA0000);
    mem_regwrite = 0;
    applyStimulus();
    chk("fwd_wb", RA, 32'h5555);

    // Register 0 is never forwarded
    quietInputs();
    id_rt = 0; mem_rd = 0; mem_regwrite = 1; mem_result = 32'hDEADBEEF;
    id_rt_data = 0;
    applyStimulus();
    chk("r0_RB", RB, 32'd0);
    chk("r0_store", ex_store_data, 32'd0);

    // Load-use: lw r8, then ADD reading r8
    quietInputs();
    id_rd = 8; id_memread = 1; id_regwrite = 1; id_rs = 1; id_rt = 2;
    applyStimulus();
    quietInputs();
    id_rs = 8; id_rt = 3; id_rd = 9; id_alufunc = 6'b100000; id_regwrite = 1;
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    applyStimulus();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    mem_rd = 8; mem_regwrite = 1; mem_result = 32'h1234;
    applyStimulus();
    chk("lu_RA", RA, 32'h1234);
    chk("lu_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_alufunc", {26'd0, alufunc}, 32'h20);

    // Capture SUB, hold for 3 cycles, then flush with hold
    quietInputs();
    id_alufunc = 6'b100010; id_rs = 4; id_rs_data = 32'h0BAD_F00D;
    applyStimulus();
    savedRa = RA; savedFunc = alufunc;
    for (int i = 0; i < 3; i++) begin
      randomInputs(31);
      hold = 1; flush = 0; rst = 0;
      #1;
      chk("hold_stall", {31'd0, stall}, 32'd1);
      applyStimulus();
      chk("hold_RA", RA, savedRa);
      chk("hold_alufunc", {26'd0, alufunc}, {26'd0, savedFunc});
    end
    hold = 1; flush = 1;
    applyStimulus();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_alufunc", {26'd0, alufunc}, 32'h20);

    // Immediate operand
    quietInputs();
    id_use_imm = 1; id_imm = 32'hFFFFFFFC; id_rt_data = 7;
    applyStimulus();
    chk("imm_RB", RB, 32'hFFFFFFFC);
    chk("imm_store", ex_store_data, 32'd7);

    // Randomized run over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      randomInputs(7);
      rst   = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
